mult_pipe: RTL and testbench
============================

Name: mult_pipe

Overview:
Pipelined, parametrised N x M multiplier for the FMDSP datapath with a valid/ready handshake on both sides. It supports per-operation signed (two's-complement) or unsigned mode. The result is delivered in carry-save form (out1, out2), so downstream adders and compressors can consume it without a carry-propagate add. It generalises the combinational wallace/dadda multiplier cell with pipelining, backpressure, a runtime signedness mode and an optional accumulate path.

Parameters:
N, 17, width of operand a (N >= 4)
M, 17, width of operand b (M >= 4)
MULT, 0, reduction tree: 0 = wallace, 1 = dadda
STAGES, 2, pipeline register stages from input acceptance to output (1..4)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair presented
in_ready  output  1  block can accept an operand pair this cycle
a  input  N  multiplicand
b  input  M  multiplier
is_signed  input  1  1 = a and b are two's complement; 0 = unsigned; sampled with a/b
out_valid  output  1  out1/out2 hold a valid result
out_ready  input  1  consumer accepts the result this cycle
out1  output  N+M  carry-save word 1
out2  output  N+M  carry-save word 2

Behaviour:
- Reset and clocking: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: all stage valid bits = 0, out_valid = 0, out1 = 0, out2 = 0, in_ready = 1 on the first cycle after reset.
- Accept/deliver:
  - An operand pair is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
- Result rule: (out1 + out2) mod 2^(N+M) equals a*b mod 2^(N+M).
  - Products are sign-extended when is_signed = 1 and zero-extended when is_signed = 0.
  - The split between out1 and out2 is implementation-defined. Benches check only the sum.
- Signed correction:
  - The Baugh-Wooley constant is injected only when is_signed = 1, using the constant with bits N and N+M-1 set.
  - Unsigned mode uses partial products with no inversion and no constant.
- Latency: exactly STAGES cycles from acceptance to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Pipeline flow:
  - Stage k loads from stage k-1 when stage k is empty or is advancing.
  - The final stage advances on out_ready.
  - This gives bubble collapse: empty stages fill even while the output is stalled.
- in_ready = stage-1 empty OR stage 1 advancing. It is combinational from out_ready and the valid bits; there is no combinational path from in_valid.
- Capacity: STAGES results in flight. With out_ready held low, the pipeline accepts exactly STAGES operations and then deasserts in_ready.
- Stability:
  - While out_valid && !out_ready, out1, out2 and out_valid hold stable.
  - Stage data registers load only on advance; idle stages do not toggle.
- Ordering: results leave strictly in acceptance order. There is no drop and no duplication.
- Simultaneous events: accept and deliver in the same cycle are both honoured, and occupancy is unchanged.
- Reset mid-operation: all in-flight operations are discarded, out_valid drops on the next cycle, and no stale result appears afterwards.
- Extreme operands:
  - Unsigned max x max produces no overflow inside N+M bits.
  - Signed min x min = 2^(N+M-2), which is representable and must be exact.

Optional Feature:
- Macro: FMDSP_MULT_ACC_EN.
- Defined:
  - Adds input port acc (1 bit), sampled with a/b.
  - When acc = 1, the result is added to the previous delivered result, giving a running sum of (out1 + out2) mod 2^(N+M).
  - The add is done in carry-save form with a 4:2 compressor in the last stage; there is no carry-propagate adder.
  - When acc = 0, the accumulator is reloaded with the new product.
  - The accumulator resets to 0 on rst.
  - Latency and handshake are unchanged.
  - The accumulator updates only when a result is delivered (out_valid && out_ready).
- Undefined: no acc port and no accumulator logic; each result is the independent product.

Test Plan:
- Reset with in_valid = 1 -> during rst, out_valid = 0 and out1 = out2 = 0; after rst, in_ready = 1 and first out_valid occurs exactly STAGES cycles after the first acceptance.
- Unsigned, N = M = 17, a = b = 0x1FFFF, is_signed = 0 -> out1 + out2 = 0x3FFFC0001.
- Signed, a = b = 0x10000 (-65536) -> sum = 0x100000000. Signed a = 0x1FFFF (-1), b = 1 -> sum = 0x3FFFFFFFF.
- Backpressure, STAGES = 2, out_ready = 0 for 5 cycles, 4 back-to-back ops issued -> exactly 2 accepted and in_ready = 0; after release, all 4 results appear in order with none lost.
- Reset pulsed with 2 ops in flight -> no result emitted afterwards; a new op yields its correct product after STAGES cycles.
- FMDSP_MULT_ACC_EN defined: ops (3,4,acc=0), (5,6,acc=1), (2,2,acc=0) -> delivered sums 12, 42, 4.

Source files
------------

// File: rtl/mult_pipe.sv
// mult_pipe: pipelined N x M multiplier with valid/ready on both sides.
// The result is delivered in carry-save form (out1 + out2 == a*b mod 2^(N+M)).
// is_signed selects two's-complement (modified Baugh-Wooley) or unsigned mode per operation.
// MULT picks the row-reduction schedule: 0 = wallace (greedy), 1 = dadda (minimal per level).
// Optional macro FMDSP_MULT_ACC_EN adds an 'acc' input and a carry-save running accumulator.
module mult_pipe #(
  parameter int N      = 17,
  parameter int M      = 17,
  parameter int MULT   = 0,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  input  logic           is_signed,
`ifdef FMDSP_MULT_ACC_EN
  input  logic           acc,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+M-1:0] out1,
  output logic [N+M-1:0] out2
);

  localparam int W    = N + M;
  localparam int R    = M + 1;
  localparam int LAST = STAGES - 1;

  // Number of 3:2 compressors applied to n rows in one reduction level.
  function automatic int grp(input int n);
    int d;
    int g;
    g = 0;
    if (n > 2) begin
      if (MULT == 1) begin
        d = 2;
        while ((d * 3) / 2 < n) d = (d * 3) / 2;
        g = n - d;
      end else begin
        g = n / 3;
      end
    end
    return g;
  endfunction

  function automatic int rows_at(input int lvl);
    int n;
    n = R;
    for (int i = 0; i < lvl; i++) n = n - grp(n);
    return n;
  endfunction

  function automatic int num_levels();
    int n;
    int l;
    n = R;
    l = 0;
    while (n > 2) begin
      n = n - grp(n);
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = num_levels();

  // Correction for the inverted sign-row bits; reduces to bits N and N+M-1 when N == M.
  localparam logic [W-1:0] BW_K = (W'(1) << (W - 1)) + (W'(1) << (N - 1)) + (W'(1) << (M - 1));

  logic [W-1:0] tree [LEVELS+1][R];

  genvar gi, gl, gk, gr;

  for (gi = 0; gi < M; gi++) begin : g_pp
    localparam logic [N-1:0] INV = (gi == M - 1) ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
    logic [N-1:0] row;
    assign row         = (a & {N{b[gi]}}) ^ (INV & {N{is_signed}});
    assign tree[0][gi] = {{M{1'b0}}, row} << gi;
  end
  assign tree[0][M] = is_signed ? BW_K : '0;

  for (gl = 0; gl < LEVELS; gl++) begin : g_lvl
    localparam int NR = rows_at(gl);
    localparam int G  = grp(NR);
    for (gk = 0; gk < G; gk++) begin : g_csa
      assign tree[gl+1][2*gk]   = tree[gl][3*gk] ^ tree[gl][3*gk+1] ^ tree[gl][3*gk+2];
      assign tree[gl+1][2*gk+1] = ((tree[gl][3*gk] & tree[gl][3*gk+1]) |
                                   (tree[gl][3*gk] & tree[gl][3*gk+2]) |
                                   (tree[gl][3*gk+1] & tree[gl][3*gk+2])) << 1;
    end
    for (gr = 3 * G; gr < NR; gr++) begin : g_pass
      assign tree[gl+1][gr-G] = tree[gl][gr];
    end
    for (gr = NR - G; gr < R; gr++) begin : g_zero
      assign tree[gl+1][gr] = '0;
    end
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] vin;
  logic [W-1:0]      s1_q [STAGES];
  logic [W-1:0]      s2_q [STAGES];
  logic [W-1:0]      d1   [STAGES];
  logic [W-1:0]      d2   [STAGES];

`ifdef FMDSP_MULT_ACC_EN
  logic [STAGES-1:0] acc_q;
  logic [STAGES-1:0] ain;
  logic [W-1:0]      acc1_q, acc2_q;
  logic [W-1:0]      src1, src2, t1, t2;
  logic              fire;
`endif

  // Load enables: a stage loads when empty or when its occupant moves on this cycle.
  always_comb begin
    ld       = '0;
    vin      = '0;
    ld[LAST] = ~vld[LAST] | out_ready;
    for (int k = LAST - 1; k >= 0; k--) ld[k] = ~vld[k] | ld[k+1];
    vin[0] = in_valid;
    for (int k = 1; k < STAGES; k++) vin[k] = vld[k-1];
  end

  // Stage inputs: the reduced tree feeds stage 0, later stages forward the previous one.
  always_comb begin
    d1[0] = tree[LEVELS][0];
    d2[0] = tree[LEVELS][1];
    for (int k = 1; k < STAGES; k++) begin
      d1[k] = s1_q[k-1];
      d2[k] = s2_q[k-1];
    end
`ifdef FMDSP_MULT_ACC_EN
    fire = vld[LAST] & out_ready;
    ain[0] = acc;
    for (int k = 1; k < STAGES; k++) ain[k] = acc_q[k-1];
    // The previous result may be leaving the output register on this very edge.
    src1 = fire ? s1_q[LAST] : acc1_q;
    src2 = fire ? s2_q[LAST] : acc2_q;
    t1   = d1[LAST] ^ d2[LAST] ^ src1;
    t2   = ((d1[LAST] & d2[LAST]) | (d1[LAST] & src1) | (d2[LAST] & src1)) << 1;
    if (ain[LAST]) begin
      d1[LAST] = t1 ^ t2 ^ src2;
      d2[LAST] = ((t1 & t2) | (t1 & src2) | (t2 & src2)) << 1;
    end
`endif
  end

  // Pipeline registers: valids follow load enables, data moves only with a valid occupant.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        s1_q[k] <= '0;
        s2_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) vld[k] <= vin[k];
        if (ld[k] && vin[k]) begin
          s1_q[k] <= d1[k];
          s2_q[k] <= d2[k];
        end
      end
    end
  end

`ifdef FMDSP_MULT_ACC_EN
  // Accumulator holds the last delivered result; acc flags travel with their operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc1_q <= '0;
      acc2_q <= '0;
      acc_q  <= '0;
    end else begin
      if (fire) begin
        acc1_q <= s1_q[LAST];
        acc2_q <= s2_q[LAST];
      end
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k] && vin[k]) acc_q[k] <= ain[k];
      end
    end
  end
`endif

  assign in_ready  = ld[0];
  assign out_valid = vld[LAST];
  assign out1      = s1_q[LAST];
  assign out2      = s2_q[LAST];

endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe (N = M = 17, STAGES = 2).
module tb_mult_pipe;
  localparam int N      = 17;
  localparam int M      = 17;
  localparam int W      = N + M;
  localparam int STAGES = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [M-1:0]   b;
  logic           is_signed;
  logic           acc;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out1, out2;
  logic [W-1:0]   sum;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int cyc      = 0;
  int t_acc    = 0;
  logic [W-1:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sum = out1 + out2;

  mult_pipe #(.N(N), .M(M), .MULT(0), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
`ifdef FMDSP_MULT_ACC_EN
    .acc       (acc),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .out2      (out2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every delivered result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        check("result", 64'(sum), 64'(e));
        n_out++;
      end
    end
  end

  task automatic send(input logic [N-1:0] av, input logic [M-1:0] bv, input logic sg,
                      input logic ac, input logic [W-1:0] ex);
    logic got;
    got       = 1'b0;
    a         = av;
    b         = bv;
    is_signed = sg;
    acc       = ac;
    in_valid  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        exp_q.push_back(ex);
        t_acc = cyc;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) check("send_timeout", 64'(got), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic measure_latency(input string tag);
    int seen;
    seen = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = cyc - t_acc;
        break;
      end
    end
    check(tag, 64'(seen), 64'(STAGES));
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] v_a [9] = '{17'h1FFFD, 17'h12345, 17'h10000, 17'h1FFFF, 17'h0FFFF,
                            17'h1FFFF, 17'h1FFFF, 17'h00000, 17'h00003};
  logic [M-1:0] v_b [9] = '{17'h00005, 17'h00010, 17'h10000, 17'h00001, 17'h10000,
                            17'h1FFFF, 17'h00001, 17'h1ABCD, 17'h00004};
  logic         v_s [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [W-1:0] v_e [9] = '{34'h3FFFFFFF1, 34'h000123450, 34'h100000000, 34'h3FFFFFFFF,
                            34'h300010000, 34'h000000001, 34'h00001FFFF, 34'h000000000,
                            34'h00000000C};

  logic [N-1:0] bp_a [4] = '{17'd7,  17'd100, 17'h1FFFE, 17'h01000};
  logic [M-1:0] bp_b [4] = '{17'd9,  17'd200, 17'h1FFFE, 17'h01000};
  logic         bp_s [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [W-1:0] bp_e [4] = '{34'h3F, 34'h4E20, 34'h4, 34'h1000000};

  initial begin
    int t_first;
    int idx;
    int n0;

    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 17'd5;
    b         = 17'd7;
    is_signed = 1'b0;
    acc       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out1", 64'(out1), 64'd0);
    check("rst_out2", 64'(out2), 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    send(17'h1FFFF, 17'h1FFFF, 1'b0, 1'b0, 34'h3FFFC0001);
    measure_latency("first_latency");

    t_first = 0;
    for (int i = 0; i < 9; i++) begin
      send(v_a[i], v_b[i], v_s[i], 1'b0, v_e[i]);
      if (i == 0) t_first = t_acc;
    end
    check("throughput", 64'(t_acc - t_first), 64'd8);
    drain();

    out_ready = 1'b0;
    n0  = n_out;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 4) begin
        a         = bp_a[idx];
        b         = bp_b[idx];
        is_signed = bp_s[idx];
        in_valid  = 1'b1;
      end
      @(negedge clk);
      if (out_valid) check("stall_hold", 64'(sum), 64'(bp_e[0]));
      if (in_ready && in_valid && idx < 4) begin
        exp_q.push_back(bp_e[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(idx), 64'd2);
    @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 2; k < 4; k++) send(bp_a[k], bp_b[k], bp_s[k], 1'b0, bp_e[k]);
    drain();
    check("bp_count", 64'(n_out - n0), 64'd4);

    out_ready = 1'b0;
    send(17'd11, 17'd13, 1'b0, 1'b0, 34'd143);
    send(17'd21, 17'd23, 1'b0, 1'b0, 34'd483);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    n0        = n_out;
    repeat (6) @(posedge clk);
    #1;
    check("no_stale", 64'(n_out - n0), 64'd0);
    send(17'h00ABC, 17'h00123, 1'b0, 1'b0, 34'hC33B4);
    measure_latency("post_rst_latency");
    drain();

`ifdef FMDSP_MULT_ACC_EN
    send(17'd3, 17'd4, 1'b0, 1'b0, 34'd12);
    send(17'd5, 17'd6, 1'b0, 1'b1, 34'd42);
    send(17'd2, 17'd2, 1'b0, 1'b0, 34'd4);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
